pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_if.sv | 31 +++
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bundle: PC request/handshake out to fetch, branch/exception resolution in from execute.
// The unit that owns the PC uses the master modport. The fetch/execute side uses the slave modport.
interface pc_fetch_if #(
    parameter int ADDRESS_SIZE = 32
);
    logic                    fetch_ready;
    logic                    fetch_valid;
    logic [ADDRESS_SIZE-1:0] fetch_pc;
    logic                    fetch_pred_taken;
    logic                    br_valid;
    logic [ADDRESS_SIZE-1:0] br_pc;
    logic                    br_conditional;
    logic [ADDRESS_SIZE-1:0] br_immediate;
    logic [ADDRESS_SIZE-1:0] br_result;
    logic                    br_pred_taken;
    logic                    exc_valid;
    logic                    flush;
    logic [15:0]             redirect_count;

    modport master (
        input  fetch_ready, br_valid, br_pc, br_conditional, br_immediate,
               br_result, br_pred_taken, exc_valid,
        output fetch_valid, fetch_pc, fetch_pred_taken, flush, redirect_count
    );

    modport slave (
        output fetch_ready, br_valid, br_pc, br_conditional, br_immediate,
               br_result, br_pred_taken, exc_valid,
        input  fetch_valid, fetch_pc, fetch_pred_taken, flush, redirect_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC generator: BOOT/RUN/BUBBLE sequencing, branch/exception redirect with one-cycle flush, saturating redirect count.
// A redirect takes effect on the next cycle. fetch_pc holds while fetch_ready is low. Optional BTB is enabled by PC_BTB_EN.
module pc_fetch_unit #(
    parameter int                      ADDRESS_SIZE     = 32,
    parameter int                      INSTRUCTION_SIZE = 4,
    parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR     = '0,
    parameter logic [ADDRESS_SIZE-1:0] EXC_VECTOR       = 32'h100,
    parameter int                      BTB_ENTRIES      = 8
) (
    input  logic      clk,
    input  logic      reset,
    pc_fetch_if.master bus
);
    localparam logic [ADDRESS_SIZE-1:0] INC        = ADDRESS_SIZE'(INSTRUCTION_SIZE);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(ADDRESS_SIZE'(INSTRUCTION_SIZE - 1));

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, BUBBLE = 2'd2} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDRESS_SIZE-1:0] r_pc;
    logic [ADDRESS_SIZE-1:0] w_pc_nxt;
    logic                    r_flush;
    logic [15:0]             r_redirect_cnt;

    logic                    w_taken;
    logic [ADDRESS_SIZE-1:0] w_br_target;
    logic                    w_br_redirect;
    logic [ADDRESS_SIZE-1:0] w_br_redirect_pc;
    logic                    w_redirect;
    logic [ADDRESS_SIZE-1:0] w_redirect_pc;
    logic                    w_btb_hit;
    logic [ADDRESS_SIZE-1:0] w_btb_tgt;

    assign w_taken     = bus.br_conditional ? (bus.br_result == '0) : 1'b1;
    assign w_br_target = bus.br_conditional ? (bus.br_pc + bus.br_immediate)
                                            : ((bus.br_immediate + bus.br_result) & ALIGN_MASK);

`ifdef PC_BTB_EN
    localparam int OFF_W = $clog2(INSTRUCTION_SIZE);
    localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;

    logic [BTB_ENTRIES-1:0]  r_btb_vld;
    logic [ADDRESS_SIZE-1:0] r_btb_tag [BTB_ENTRIES];
    logic [ADDRESS_SIZE-1:0] r_btb_tgt [BTB_ENTRIES];
    logic [IDX_W-1:0]        w_fetch_idx;
    logic [IDX_W-1:0]        w_br_idx;
    logic                    w_btb_upd;

    assign w_fetch_idx = bus.fetch_pc[OFF_W +: IDX_W];
    assign w_br_idx    = bus.br_pc[OFF_W +: IDX_W];
    assign w_btb_hit   = r_btb_vld[w_fetch_idx] && (r_btb_tag[w_fetch_idx] == bus.fetch_pc);
    assign w_btb_tgt   = r_btb_tgt[w_fetch_idx];
    // A branch squashed by a concurrent exception must not train the BTB.
    assign w_btb_upd   = bus.br_valid && bus.br_conditional && !bus.exc_valid;

    assign w_br_redirect    = bus.br_valid && (w_taken != bus.br_pred_taken);
    assign w_br_redirect_pc = w_taken ? w_br_target : (bus.br_pc + INC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btb_vld <= '0;
        end else if (w_btb_upd) begin
            if (w_taken) begin
                r_btb_vld[w_br_idx] <= 1'b1;
            end else if (r_btb_tag[w_br_idx] == bus.br_pc) begin
                r_btb_vld[w_br_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_btb_upd && w_taken) begin
            r_btb_tag[w_br_idx] <= bus.br_pc;
            r_btb_tgt[w_br_idx] <= w_br_target;
        end
    end
`else
    logic w_unused_pred;

    assign w_btb_hit        = 1'b0;
    assign w_btb_tgt        = '0;
    assign w_br_redirect    = bus.br_valid && w_taken;
    assign w_br_redirect_pc = w_br_target;
    assign w_unused_pred    = &{1'b0, bus.br_pred_taken};
`endif

    assign w_redirect    = bus.exc_valid || w_br_redirect;
    assign w_redirect_pc = bus.exc_valid ? EXC_VECTOR : w_br_redirect_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect) begin
            w_state_nxt = BUBBLE;
        end else begin
            case (r_state)
                BOOT, BUBBLE: w_state_nxt = RUN;
                default:      w_state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        bus.fetch_valid      = (r_state == RUN);
        bus.fetch_pred_taken = (r_state == RUN) && w_btb_hit;
        bus.fetch_pc         = r_pc;
        bus.flush            = r_flush;
        bus.redirect_count   = r_redirect_cnt;
    end

    // A redirect overrides any fetch handshake in the same cycle.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redirect) begin
            w_pc_nxt = w_redirect_pc;
        end else if ((r_state == RUN) && bus.fetch_ready) begin
            w_pc_nxt = bus.fetch_pred_taken ? w_btb_tgt : (r_pc + INC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_VECTOR;
            r_flush        <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_flush <= w_redirect;
            if (w_redirect && (r_redirect_cnt != 16'hFFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
        end
    end
endmodule
